// File: rtl/bmem_line_adapter.sv
// rtl/bmem_line_adapter.sv - 256-bit line requester to 64-bit banked memory bridge
// One request in flight; reads gather tagged beats, writes stream beats out.
module bmem_line_adapter #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     dfp_addr,
  input  logic                            dfp_read,
  input  logic                            dfp_write,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] dfp_wdata,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] dfp_rdata,
  output logic                            dfp_resp,
  output logic [31:0]                     bmem_addr,
  output logic                            bmem_read,
  output logic                            bmem_write,
  output logic [BEAT_WIDTH-1:0]           bmem_wdata,
  input  logic                            bmem_ready,
  input  logic [31:0]                     bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]           bmem_rdata,
  input  logic                            bmem_rvalid
);

  localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN;
  localparam int CNT_W      = $clog2(BURST_LEN);
  localparam int OFF_W      = $clog2(LINE_WIDTH / 8);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_REQ   = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_BURST = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  last_beat;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];
  assign last_beat        = (cnt_q == CNT_W'(BURST_LEN - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        // Read takes priority; a held write is picked up on a later accept.
        if (dfp_read) begin
          addr_d  = {dfp_addr[31:OFF_W], OFF_W'(0)};
          state_d = RD_REQ;
        end else if (dfp_write) begin
          addr_d  = {dfp_addr[31:OFF_W], OFF_W'(0)};
          wdata_d = dfp_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Beats tagged with a different address belong to someone else.
        if (bmem_rvalid && (bmem_raddr == addr_q)) begin
          rdata_d[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] = bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : 32'h0;
  assign bmem_wdata = bmem_write ? wdata_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] : '0;
  assign dfp_resp   = (state_q == RESP);
  assign dfp_rdata  = rdata_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb/tb_bmem_line_adapter.sv - scoreboard bench for bmem_line_adapter
// Stimulus pushes expected commands/responses; a negedge monitor pops and compares.
module tb_bmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  bmem_line_adapter dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
  } resp_t;

  logic [31:0] rdq[$];
  wr_t         wrq[$];
  resp_t       respq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int resp_count = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  initial begin
    logic [31:0] ea;
    wr_t         ew;
    resp_t       er;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bmem_read && bmem_ready) begin
          chk("rd_cmd_expected", 256'(rdq.size() != 0), 256'd1);
          if (rdq.size() != 0) begin
            ea = rdq.pop_front();
            chk("rd_cmd_addr", 256'(bmem_addr), 256'(ea));
          end
        end
        if (bmem_write && bmem_ready) begin
          chk("wr_beat_expected", 256'(wrq.size() != 0), 256'd1);
          if (wrq.size() != 0) begin
            ew = wrq.pop_front();
            chk("wr_beat_addr", 256'(bmem_addr), 256'(ew.addr));
            chk("wr_beat_data", 256'(bmem_wdata), 256'(ew.data));
          end
        end
        if (dfp_resp) begin
          resp_count++;
          chk("resp_expected", 256'(respq.size() != 0), 256'd1);
          if (respq.size() != 0) begin
            er = respq.pop_front();
            if (er.is_rd) chk("resp_rdata", dfp_rdata, er.line);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_resp(input bit drop_rd, input bit drop_wr, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (dfp_resp) begin
        found = 1'b1;
        at = cyc;
        if (drop_rd) dfp_read = 1'b0;
        if (drop_wr) dfp_write = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("resp_seen", 256'(found), 256'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bmem_read"},  256'(bmem_read),  256'd0);
    chk({tag, "_bmem_write"}, 256'(bmem_write), 256'd0);
    chk({tag, "_bmem_addr"},  256'(bmem_addr),  256'd0);
    chk({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'd0);
    chk({tag, "_dfp_resp"},   256'(dfp_resp),   256'd0);
    chk({tag, "_dfp_rdata"},  dfp_rdata,        256'd0);
  endtask

  task automatic do_read(input logic [31:0] raw, input logic [31:0] aligned, input int stall,
                         input int bad_at, input logic [255:0] line);
    int c0;
    int at;
    int k;
    int nb;
    resp_t r;
    r.is_rd = 1'b1;
    r.line  = line;
    rdq.push_back(aligned);
    respq.push_back(r);
    dfp_addr   = raw;
    dfp_read   = 1'b1;
    bmem_ready = 1'b1;
    c0 = cyc;
    @(posedge clk);
    #1;
    for (int j = 0; j <= stall; j++) begin
      bmem_ready = (j == stall);
      chk("rd_req_read", 256'(bmem_read), 256'd1);
      chk("rd_req_addr", 256'(bmem_addr), 256'(aligned));
      @(posedge clk);
      #1;
    end
    k  = 0;
    nb = (bad_at >= 0) ? 5 : 4;
    for (int s = 0; s < nb; s++) begin
      bmem_rvalid = 1'b1;
      if (s == bad_at) begin
        bmem_raddr = 32'hDEAD_0000;
        bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        bmem_raddr = aligned;
        bmem_rdata = line[64*k +: 64];
        k++;
      end
      chk("rd_wait_no_read", 256'(bmem_read), 256'd0);
      @(posedge clk);
      #1;
    end
    bmem_rvalid = 1'b0;
    wait_resp(1'b1, 1'b0, at);
    chk("rd_latency", 256'(at - c0), 256'(2 + stall + nb));
  endtask

  task automatic do_write(input logic [31:0] raw, input logic [31:0] aligned, input logic [255:0] wd,
                          input bit stall, input int c0_off);
    int c0;
    int at;
    wr_t w;
    resp_t r;
    for (int i = 0; i < 4; i++) begin
      w.addr = aligned;
      w.data = wd[64*i +: 64];
      wrq.push_back(w);
    end
    r.is_rd = 1'b0;
    r.line  = '0;
    respq.push_back(r);
    dfp_addr  = raw;
    dfp_wdata = wd;
    dfp_write = 1'b1;
    c0 = cyc + c0_off;
    repeat (1 + c0_off) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 4; i++) begin
      if (stall) begin
        bmem_ready = 1'b0;
        chk("wr_stall_write", 256'(bmem_write), 256'd1);
        chk("wr_stall_wdata", 256'(bmem_wdata), 256'(wd[64*i +: 64]));
        @(posedge clk);
        #1;
      end
      bmem_ready = 1'b1;
      chk("wr_write", 256'(bmem_write), 256'd1);
      chk("wr_wdata", 256'(bmem_wdata), 256'(wd[64*i +: 64]));
      @(posedge clk);
      #1;
    end
    wait_resp(1'b0, 1'b1, at);
    chk("wr_latency", 256'(at - c0), 256'(stall ? 9 : 5));
  endtask

  initial begin
    int rc0;
    rst         = 1'b1;
    dfp_addr    = '0;
    dfp_read    = 1'b0;
    dfp_write   = 1'b0;
    dfp_wdata   = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;
    idle(3);
    chk_idle_outputs("in_reset");
    rst = 1'b0;
    idle(1);
    chk_idle_outputs("after_reset");

    // Plain read, ready always high
    do_read(32'h1234_5678, 32'h1234_5660, 0, -1,
            {64'h0D, 64'h0C, 64'h0B, 64'h0A});
    idle(2);

    // Write with ready low on alternate cycles
    do_write(32'h8000_0020, 32'h8000_0020, {64'h4, 64'h3, 64'h2, 64'h1}, 1'b1, 0);
    idle(2);

    // Read stalled 3 cycles, foreign beat mixed in
    do_read(32'h0000_0ABC, 32'h0000_0AA0, 3, 2,
            {64'h44, 64'h33, 64'h22, 64'h11});
    idle(2);

    // Read and write together: read first, held write next
    rc0 = resp_count;
    dfp_write = 1'b1;
    dfp_wdata = {64'hCAFE_0004, 64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001};
    do_read(32'h0000_1047, 32'h0000_1040, 0, -1,
            {64'h5555, 64'h6666, 64'h7777, 64'h8888});
    do_write(32'h0000_1047, 32'h0000_1040,
             {64'hCAFE_0004, 64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001}, 1'b0, 1);
    idle(3);
    chk("dual_resp_count", 256'(resp_count - rc0), 256'd2);

    // Reset in RD_WAIT after two beats
    rc0 = resp_count;
    rdq.push_back(32'h0000_2000);
    dfp_addr   = 32'h0000_2000;
    dfp_read   = 1'b1;
    bmem_ready = 1'b1;
    idle(2);
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_2000;
      bmem_rdata  = 64'hE0 + 64'(i);
      idle(1);
    end
    bmem_rvalid = 1'b0;
    dfp_read    = 1'b0;
    rst         = 1'b1;
    idle(1);
    chk_idle_outputs("mid_reset");
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h0000_2000;
      bmem_rdata  = 64'hE2 + 64'(i);
      idle(1);
      chk("late_beat_no_resp", 256'(dfp_resp), 256'd0);
      chk("late_beat_no_read", 256'(bmem_read), 256'd0);
    end
    bmem_rvalid = 1'b0;
    idle(2);
    chk("reset_no_resp", 256'(resp_count - rc0), 256'd0);
    do_read(32'h0000_2000, 32'h0000_2000, 0, -1,
            {64'hF4, 64'hF3, 64'hF2, 64'hF1});
    idle(2);

    // Back-to-back writes
    do_write(32'h0000_0040, 32'h0000_0040, {64'h14, 64'h13, 64'h12, 64'h11}, 1'b0, 0);
    do_write(32'h0000_0060, 32'h0000_0060, {64'h24, 64'h23, 64'h22, 64'h21}, 1'b0, 1);
    idle(3);

    chk("rdq_drained",   256'(rdq.size()),   256'd0);
    chk("wrq_drained",   256'(wrq.size()),   256'd0);
    chk("respq_drained", 256'(respq.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
